// File: rtl/axi2sdram_cmd_arbiter.sv
// Picks one AXI write or read request, packs it as {op,strb,addr,data} and pushes it to the SDRAM command FIFO.
// Round-robin tie-break by default; define WR_FIXED_PRIO_EN to make writes always beat reads.
module axi2sdram_cmd_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int CMD_WIDTH       = 1 + STRB_WIDTH + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req_valid,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic [STRB_WIDTH-1:0] wr_req_strb,
  output logic                  wr_req_ready,
  input  logic                  rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_req_ready,
  output logic                  fifo_wr_en,
  output logic [CMD_WIDTH-1:0]  fifo_data_in,
  input  logic                  fifo_full,
  input  logic                  rsp_pop,
  output logic [3:0]            rd_outstanding,
  output logic                  busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PUSH = 1'b1;
  localparam logic [3:0] MAX_CREDITS = 4'(MAX_OUTSTANDING);

  logic [0:0]           state;
  logic [CMD_WIDTH-1:0] cmd;
  logic [3:0]           credits;
  logic                 wr_elig, rd_elig;
  logic                 grant_wr, grant_rd;
  logic                 push, credit_inc, credit_dec;
`ifndef WR_FIXED_PRIO_EN
  logic                 last_wr;
`endif

  assign wr_elig = wr_req_valid;
  assign rd_elig = rd_req_valid && (credits < MAX_CREDITS);

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (!reset && state == IDLE) begin
`ifdef WR_FIXED_PRIO_EN
      grant_wr = wr_elig;
      grant_rd = rd_elig && !wr_elig;
`else
      if (wr_elig && rd_elig) begin
        grant_wr = !last_wr;
        grant_rd = last_wr;
      end else begin
        grant_wr = wr_elig;
        grant_rd = rd_elig;
      end
`endif
    end
  end

  // Gated by reset so a stalled command is dropped rather than pushed during reset.
  assign push       = !reset && (state == PUSH) && !fifo_full;
  assign credit_inc = push && !cmd[CMD_WIDTH-1];
  assign credit_dec = rsp_pop && (credits != 4'd0);

  assign wr_req_ready   = grant_wr;
  assign rd_req_ready   = grant_rd;
  assign fifo_wr_en     = push;
  assign fifo_data_in   = cmd;
  assign rd_outstanding = credits;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cmd     <= '0;
      credits <= 4'd0;
`ifndef WR_FIXED_PRIO_EN
      last_wr <= 1'b0;
`endif
    end else begin
      if (grant_wr) begin
        state <= PUSH;
        cmd   <= {1'b1, wr_req_strb, wr_req_addr, wr_req_data};
      end else if (grant_rd) begin
        state <= PUSH;
        cmd   <= {1'b0, {STRB_WIDTH{1'b0}}, rd_req_addr, {DATA_WIDTH{1'b0}}};
      end else if (push) begin
        state <= IDLE;
      end
`ifndef WR_FIXED_PRIO_EN
      if (grant_wr || grant_rd) last_wr <= grant_wr;
`endif
      // A pop alongside a read push cancels out, even when the count is zero.
      if (credit_inc && !rsp_pop)      credits <= credits + 4'd1;
      else if (!credit_inc && credit_dec) credits <= credits - 4'd1;
    end
  end

endmodule

// File: tb/tb_axi2sdram_cmd_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic checked against a transaction-level model.
module tb_axi2sdram_cmd_arbiter;
  localparam int AW = 32, DW = 32, SW = 4, MAXO = 4;
  localparam int CW = 1 + SW + AW + DW;

  logic          clk = 1'b0;
  logic          reset, wr_req_valid, rd_req_valid, fifo_full, rsp_pop;
  logic [AW-1:0] wr_req_addr, rd_req_addr;
  logic [DW-1:0] wr_req_data;
  logic [SW-1:0] wr_req_strb;
  logic          wr_req_ready, rd_req_ready, fifo_wr_en, busy;
  logic [CW-1:0] fifo_data_in;
  logic [3:0]    rd_outstanding;

  axi2sdram_cmd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_strb(wr_req_strb), .wr_req_ready(wr_req_ready),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .fifo_full(fifo_full),
    .rsp_pop(rsp_pop), .rd_outstanding(rd_outstanding), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  // Transaction model: at most one accepted command waits for the FIFO.
  logic [CW-1:0] staged[$];
  logic [CW-1:0] m_dout = '0;
  int            m_credits = 0;
  bit            m_last_wr = 1'b0;
  // Requester side: number of queued requests per channel.
  int  wr_left = 0, rd_left = 0;
  bit  wr_new = 1'b1, rd_new = 1'b1;
  byte gq[$];
  int  pushes = 0;
  logic [CW-1:0] held;
  string exp_ord;
  int  budget;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic step();
    bit ew, er, eg_w, eg_r, e_push, op_wr;
    logic [CW-1:0] word;
    if (wr_new) begin
      wr_req_addr = $urandom; wr_req_data = $urandom; wr_req_strb = SW'($urandom); wr_new = 1'b0;
    end
    if (rd_new) begin
      rd_req_addr = $urandom; rd_new = 1'b0;
    end
    wr_req_valid = (wr_left > 0);
    rd_req_valid = (rd_left > 0);
    #1;
    e_push = (staged.size() > 0) && !fifo_full && !reset;
    eg_w = 1'b0; eg_r = 1'b0;
    if (!reset && staged.size() == 0) begin
      ew = wr_req_valid;
      er = rd_req_valid && (m_credits < MAXO);
`ifdef WR_FIXED_PRIO_EN
      eg_w = ew; eg_r = er && !ew;
`else
      if (ew && er) begin eg_w = !m_last_wr; eg_r = m_last_wr; end
      else begin eg_w = ew; eg_r = er; end
`endif
    end
    chk("wr_req_ready", wr_req_ready, eg_w);
    chk("rd_req_ready", rd_req_ready, eg_r);
    chk("fifo_wr_en", fifo_wr_en, e_push);
    chk("busy", busy, staged.size() > 0);
    chk("rd_outstanding", rd_outstanding, m_credits);
    chk("fifo_data_in", fifo_data_in, m_dout);
    if (wr_req_ready) gq.push_back("W");
    if (rd_req_ready) gq.push_back("R");
    if (fifo_wr_en) pushes++;
    if (reset) begin
      staged.delete(); m_credits = 0; m_last_wr = 1'b0; m_dout = '0;
    end else begin
      op_wr = (staged.size() > 0) ? staged[0][CW-1] : 1'b1;
      if (e_push) staged.delete();
      if (e_push && !op_wr && !rsp_pop) m_credits++;
      else if (!(e_push && !op_wr) && rsp_pop && m_credits > 0) m_credits--;
      if (eg_w) begin
        word = {1'b1, wr_req_strb, wr_req_addr, wr_req_data};
        staged.push_back(word); m_dout = word; m_last_wr = 1'b1;
      end else if (eg_r) begin
        word = {1'b0, {SW{1'b0}}, rd_req_addr, {DW{1'b0}}};
        staged.push_back(word); m_dout = word; m_last_wr = 1'b0;
      end
    end
    if (eg_w) begin wr_left--; wr_new = 1'b1; end
    if (eg_r) begin rd_left--; rd_new = 1'b1; end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; fifo_full = 1'b0; rsp_pop = 1'b0;
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    wr_req_addr = '0; wr_req_data = '0; wr_req_strb = '0; rd_req_addr = '0;
    @(posedge clk); @(negedge clk);
    step(); step();
    reset = 1'b0;
    repeat (3) step();
    chk("idle_no_push", pushes, 0);

    // Tie: both channels keep requesting.
    gq.delete(); wr_left = 4; rd_left = 4;
    repeat (8) step();
`ifdef WR_FIXED_PRIO_EN
    exp_ord = "WWWW";
`else
    exp_ord = "WRWR";
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("tie_order_%0d", i), gq[i], exp_ord[i]);
    rsp_pop = 1'b1;
    budget = 0;
    while ((wr_left > 0 || rd_left > 0 || staged.size() > 0 || m_credits > 0) && budget < 100) begin
      step(); budget++;
    end
    chk("drain_timeout", budget < 100, 1'b1);
    rsp_pop = 1'b0; step();

    // Single write with a known payload.
    gq.delete(); wr_left = 1; wr_new = 1'b0;
    wr_req_addr = 32'h10; wr_req_data = 32'hDEADBEEF; wr_req_strb = 4'hF;
    step();
    chk("single_grant", gq.size(), 1);
    #1;
    chk("single_push", fifo_wr_en, 1'b1);
    chk("single_word", fifo_data_in, {1'b1, 4'hF, 32'h10, 32'hDEADBEEF});
    step(); step();

    // Credits: five reads, no responses.
    gq.delete(); rd_left = 5;
    repeat (14) step();
    chk("credit_grants", gq.size(), 4);
    chk("credit_stalled", rd_left, 1);
    #1; chk("credit_full", rd_outstanding, 4);
    rsp_pop = 1'b1; step(); rsp_pop = 1'b0;
    step(); step();
    #1; chk("credit_refill", rd_outstanding, 4);
    rd_left = 1;
    rsp_pop = 1'b1; step(); rsp_pop = 1'b0;
    step();
    rsp_pop = 1'b1; step(); rsp_pop = 1'b0;
    #1; chk("credit_pop_and_push", rd_outstanding, 3);

    // Backpressure during PUSH.
    fifo_full = 1'b1; wr_left = 1;
    step();
    #1; held = fifo_data_in;
    pushes = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_busy", busy, 1'b1);
      chk("bp_no_push", fifo_wr_en, 1'b0);
      chk("bp_stable", fifo_data_in, held);
      step();
    end
    fifo_full = 1'b0; step(); step();
    chk("bp_single_push", pushes, 1);

    // Reset during a PUSH stall.
    fifo_full = 1'b1; wr_left = 1;
    step(); repeat (3) step();
    reset = 1'b1; step(); reset = 1'b0; fifo_full = 1'b0;
    pushes = 0;
    repeat (4) step();
    chk("rst_no_push", pushes, 0);
    #1;
    chk("rst_idle", busy, 1'b0);
    chk("rst_credits", rd_outstanding, 0);
    gq.delete(); wr_left = 1; rd_left = 1;
    repeat (4) step();
    chk("rst_first_tie", gq[0], "W");

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if (wr_left == 0 && $urandom_range(3) == 0) wr_left = $urandom_range(3, 1);
      if (rd_left == 0 && $urandom_range(3) == 0) rd_left = $urandom_range(3, 1);
      fifo_full = ($urandom_range(3) == 0);
      rsp_pop   = ($urandom_range(2) == 0);
      reset     = ($urandom_range(99) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi2sdram_cmd_arbiter.md
Name: axi2sdram_cmd_arbiter

Overview:
- Single-clock arbiter on the AXI side of the bridge.
- Accepts write requests (addr/data/strb) and read requests (addr) from the AXI-Lite slave front end.
- Selects one request, packs it into a command word and pushes it into the SDRAM command FIFO write port.
- Limits in-flight reads with a credit counter so the read-response path cannot overflow.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, write data width; must be a multiple of 8.
- MAX_OUTSTANDING, 4, maximum reads pushed but not yet answered; range 1..15.
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width (derived).
- CMD_WIDTH, 1+STRB_WIDTH+ADDR_WIDTH+DATA_WIDTH, command word width (derived, 69 at defaults).

Ports:
- clk  in  1  block clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_req_valid  in  1  write request pending
- wr_req_addr  in  ADDR_WIDTH  write address
- wr_req_data  in  DATA_WIDTH  write data
- wr_req_strb  in  STRB_WIDTH  byte strobes
- wr_req_ready  out  1  one-cycle accept pulse for the write request
- rd_req_valid  in  1  read request pending
- rd_req_addr  in  ADDR_WIDTH  read address
- rd_req_ready  out  1  one-cycle accept pulse for the read request
- fifo_wr_en  out  1  push strobe to command FIFO
- fifo_data_in  out  CMD_WIDTH  command word {op, strb, addr, data}; op=1 write, op=0 read
- fifo_full  in  1  command FIFO full
- rsp_pop  in  1  one read response consumed; returns one credit
- rd_outstanding  out  4  current read credit usage
- busy  out  1  high when state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state=IDLE; fifo_wr_en=0; fifo_data_in=0; wr_req_ready=0; rd_req_ready=0; rd_outstanding=0; busy=0; last_grant=READ, so a write wins the first tie.
- FSM states: IDLE and PUSH.
- IDLE, eligibility:
  - write is eligible when wr_req_valid=1.
  - read is eligible when rd_req_valid=1 and rd_outstanding < MAX_OUTSTANDING.
- IDLE, winner selection: if only one request is eligible, it wins. If both are eligible, the winner is the opposite of last_grant (round-robin).
- IDLE, winner accepted:
  - pulse the winner's ready for exactly one cycle;
  - latch the command word;
  - update last_grant;
  - go to PUSH next cycle.
  - If nothing is eligible, stay in IDLE.
- Requester contract: hold valid and payload stable until ready; drop or replace valid in the cycle after ready.
- PUSH:
  - fifo_data_in holds the latched word throughout.
  - fifo_wr_en = !fifo_full, combinational from the state.
  - When fifo_wr_en=1, return to IDLE next cycle.
  - While fifo_full=1, stay in PUSH with fifo_wr_en=0, indefinitely.
- Latency and throughput: request visible in cycle N gives ready in cycle N and fifo_wr_en in cycle N+1 (FIFO not full). Peak rate is one command per 2 cycles.
- Read command encoding: strb and data fields are zero.
- Credit counter update:
  - +1 on each cycle with fifo_wr_en=1 and op=0.
  - −1 on rsp_pop.
  - Both in the same cycle: unchanged.
  - rsp_pop at 0: ignored, counter stays 0.
  - Never exceeds MAX_OUTSTANDING.
- Credit exhausted: with rd_outstanding=MAX_OUTSTANDING, reads are not eligible but writes still proceed.
- Reset mid-operation: a latched command in PUSH is discarded, no push occurs, and credits clear.

Optional Feature:
- Macro: WR_FIXED_PRIO_EN.
- Defined: fixed priority, where an eligible write always beats an eligible read; last_grant is not used.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → all outputs 0; no ready or fifo_wr_en while valids are low.
- Single write, addr=0x10, data=0xDEADBEEF, strb=0xF, FIFO not full → wr_req_ready pulses in cycle N; fifo_wr_en=1 in cycle N+1; fifo_data_in={1,0xF,0x10,0xDEADBEEF}.
- Both valid continuously, 4 grants → order W,R,W,R. With WR_FIXED_PRIO_EN defined → W,W,W,W.
- Credits: MAX_OUTSTANDING=4, 5 reads queued, no rsp_pop → 4 pushes, rd_outstanding=4, 5th read stalled. Then one rsp_pop → 5th read pushed, rd_outstanding returns to 4. rsp_pop and read push in the same cycle → count unchanged.
- Backpressure: fifo_full=1 for 10 cycles during PUSH → fifo_wr_en=0 and busy=1 throughout; data stable; single push on the cycle fifo_full drops.
- Reset asserted during a PUSH stall → no push afterwards; state IDLE; rd_outstanding=0; next write wins the tie.
